// File: rtl/seq_add_sub.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB chunk first.
// Define SEQ_ADD_SUB_SAT_EN to saturate the sum on signed overflow (default build wraps).
module seq_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("seq_add_sub: WIDTH must be >= 2 and a multiple of DIGIT (1..WIDTH)");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                    state_q, state_d;
    logic         [CNT_W-1:0]  cnt;
    logic                      carry;
    logic         [WIDTH-1:0]  a_r, b_r;
    logic signed  [WIDTH-1:0]  sum_r;
    logic                      cout_r, ovf_r;
    logic         [DIGIT:0]    ext;
    logic         [WIDTH-1:0]  sum_shift;
    logic                      last;
    logic                      ovf_n;

    function automatic logic signed [WIDTH-1:0] sat_value(input logic a_msb);
        sat_value = {a_msb, {(WIDTH-1){~a_msb}}};
    endfunction

    // Chunk adder on the low DIGIT bits of the shifting operand registers
    assign ext       = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign sum_shift = (sum_r >> DIGIT) | (WIDTH'(ext[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign last      = (cnt == CNT_W'(N - 1));
    // On the final chunk a_r/b_r hold the operand MSBs; a^b^s recovers the carry into the MSB
    assign ovf_n     = a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ ext[DIGIT-1] ^ ext[DIGIT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = BUSY;
            BUSY:    if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            carry  <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    a_r   <= a_r >> DIGIT;
                    b_r   <= b_r >> DIGIT;
                    carry <= ext[DIGIT];
                    cnt   <= cnt + 1'b1;
                    sum_r <= sum_shift;
                    if (last) begin
                        cout_r <= ext[DIGIT];
                        ovf_r  <= ovf_n;
`ifdef SEQ_ADD_SUB_SAT_EN
                        if (ovf_n) sum_r <= sat_value(a_r[DIGIT-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_seq_add_sub.sv
// Directed-vector bench for seq_add_sub at WIDTH=16, DIGIT=4.
module tb_seq_add_sub;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
`ifdef SEQ_ADD_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin, sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout, ovf;

    int vectors = 0;
    int miscompares = 0;

    seq_add_sub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation, wait for the result and check latency and values; leaves DUT in DONE.
    task automatic start_and_wait(input string tag, input logic [15:0] va, input logic [15:0] vb,
                                  input logic vcin, input logic vsub,
                                  input logic [15:0] esum, input logic ecout, input logic eovf);
        int n;
        a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF;
        check({tag, "_busy_rdy"}, in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, 4);
        check({tag, "_sum"}, sum, esum);
        check({tag, "_cout"}, cout, ecout);
        check({tag, "_ovf"}, ovf, eovf);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_rdy"}, in_ready, 1);
        check({tag, "_idle_vld"}, out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick(); tick();
        check("rst_rdy", in_ready, 1);
        check("rst_vld", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick();

        start_and_wait("add1", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
        drain("add1");
        start_and_wait("addwrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        drain("addwrap");
        start_and_wait("sub1", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        drain("sub1");
        start_and_wait("subcin", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
        drain("subcin");
        start_and_wait("addovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
                       SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);
        drain("addovf");
        start_and_wait("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1,
                       SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1);
        drain("subovf");

        // Back-pressure: result must hold while out_ready is low and new inputs are ignored
        start_and_wait("hold", 16'h0100, 16'h0023, 1'b1, 1'b0, 16'h0124, 1'b0, 1'b0);
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_sum", sum, 16'h0124);
            check("hold_vld", out_valid, 1);
            check("hold_rdy", in_ready, 0);
        end
        in_valid = 1'b0;
        drain("hold");

        // Reset during the second BUSY cycle discards the operation
        a = 16'h1234; b = 16'h0FFF; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_rdy", in_ready, 1);
        check("midrst_vld", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        check("midrst_ovf", ovf, 0);
        rst_n = 1'b1;
        tick();
        start_and_wait("postrst", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        drain("postrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
